// File: rtl/seq_detect_pkg.sv
// Shared defaults and helpers for the parametrised serial pattern detector.
package seq_detect_pkg;

  localparam int unsigned SEQ_DEF_PAT_W = 3;
  localparam logic [2:0]  SEQ_DEF_PAT   = 3'b101;
  localparam int unsigned SEQ_DEF_CNT_W = 8;

  // Width needed to hold a history fill count of 0..pat_w.
  function automatic int unsigned fill_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter used for the optional match counter
// (built only when SEQ_DETECT_HIT_CNT_EN is defined).
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with loadable pattern and overlap control.
// Optional saturating hit counter guarded by SEQ_DETECT_HIT_CNT_EN.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned      PAT_W     = SEQ_DEF_PAT_W,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(SEQ_DEF_PAT),
  parameter int unsigned      CNT_W     = SEQ_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in,
  input  logic             in_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  output logic             out,
  output logic [CNT_W-1:0] hit_count
);

  localparam int unsigned       FILL_W   = fill_w(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              out_q, out_d;
  logic [PAT_W-1:0]  hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              accept;
  logic              match;

  // Next-state: pattern load wins over a simultaneous data bit.
  always_comb begin
    hist_d     = hist_q;
    pat_d      = pat_q;
    fill_d     = fill_q;
    out_d      = out_q;
    accept     = in_valid & ~pat_load;
    hist_shift = {hist_q[PAT_W-2:0], in};
    fill_inc   = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FILL_W'(1);
    match      = (fill_inc == FILL_MAX) && (hist_shift == pat_q);

    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
      out_d  = 1'b0;
    end else if (in_valid) begin
      hist_d = hist_shift;
      fill_d = (match && !overlap) ? '0 : fill_inc;
      out_d  = match;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      pat_q  <= RESET_PAT;
      fill_q <= '0;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      pat_q  <= pat_d;
      fill_q <= fill_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

`ifdef SEQ_DETECT_HIT_CNT_EN
  sat_counter #(
    .W (CNT_W)
  ) u_hit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (accept & match),
    .count   (hit_count)
  );
`else
  assign hit_count = '0;
`endif

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector: accepts one bit per qualified cycle and asserts a Moore-style `out` when the most recent `PAT_W` accepted bits equal a runtime-loadable pattern. It generalises the fixed four-state "101" detector to any pattern width from 2 to 32 bits. It adds selectable overlapping and non-overlapping matching, an input qualifier, and an optional saturating hit counter. It sits in the serial-monitor path, fed by a bit stream with an enable.

## Interface
- `PAT_W`, 3: pattern length in bits; legal range 2..32.
- `RESET_PAT`, 3'b101: pattern register value after reset; `PAT_W` bits wide.
- `CNT_W`, 8: hit-counter width; legal range 1..32.
- `clk`  in  1  clock; all state is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in`  in  1  serial data bit.
- `in_valid`  in  1  `in` is accepted on a rising edge only when this is high.
- `pat_load`  in  1  load `pat_in` into the pattern register.
- `pat_in`  in  PAT_W  new pattern; bit `PAT_W-1` is the earliest bit in time.
- `overlap`  in  1  1 = overlapping matches; 0 = history restarts after each match.
- `out`  out  1  match flag for the most recently accepted bit.
- `hit_count`  out  CNT_W  saturating match count.

## Operation
- Internal state:
  - `hist[PAT_W-1:0]`: shift register; each accepted bit enters at bit 0 and older bits shift left.
  - `fill`: count of valid history bits, 0..PAT_W, `$clog2(PAT_W+1)` bits wide; saturates at `PAT_W`.
  - `pat`: the pattern register.
- Accept cycle (`in_valid`=1, `pat_load`=0):
  - Next history: `{hist[PAT_W-2:0], in}`.
  - Next fill: `min(fill+1, PAT_W)`.
  - `match` = (next fill == `PAT_W`) and (next history == `pat`).
- On an accept cycle:
  - `out` <= `match`.
  - If `match` and `overlap`=0, `fill` <= 0. `hist` still loads normally.
  - If `match` and the counter is compiled in, `hit_count` increments, saturating at all-ones.
- Idle cycle (`in_valid`=0, `pat_load`=0): all state holds, including `out`.
- `pat_load`=1:
  - `pat` <= `pat_in`, `hist` <= 0, `fill` <= 0, `out` <= 0.
  - `hit_count` is unchanged.
  - `pat_load` has priority: a simultaneous `in_valid` bit is dropped.
- `overlap` is sampled on each accept cycle and may change between bits.
- Reset (`reset_n`=0, asynchronous):
  - `pat` = `RESET_PAT`.
  - `hist`, `fill`, `out` and `hit_count` = 0.
  - Reset mid-sequence discards the partial history. The first match after release needs `PAT_W` fresh bits.
- Reset is asserted asynchronously. Deassertion is assumed synchronised upstream to `clk`.

## Timing
- `out` is registered. It rises on the clock edge that accepts the final pattern bit and is visible in the following cycle. This matches the original fixed detector's Moore timing.
- `hit_count` updates on the same edge as `out`.
- A new pattern takes effect for the bit accepted on the cycle after `pat_load`.
- Overlap mode: consecutive matches are possible every cycle, e.g. pattern 11 on the stream 1,1,1.
- Non-overlap mode: the minimum spacing between matches is `PAT_W` accepted bits.
- No combinational path from any input to any output.

## Configuration
- `SEQ_DETECT_HIT_CNT_EN` defined: the `CNT_W`-bit saturating counter is instantiated and drives `hit_count`.
- Not defined: no counter flops are built, and `hit_count` is tied to 0.
- The port list is identical in both cases.

## Structure
- Package `seq_detect_pkg` holds:
  - default constants `SEQ_DEF_PAT_W` = 3, `SEQ_DEF_PAT` = 3'b101, `SEQ_DEF_CNT_W` = 8;
  - the function `fill_w(pat_w)` returning `$clog2(pat_w+1)`.
- One sub-module, `sat_counter` (parameters `W`; ports `clk`, `reset_n`, `inc`, `count`), compiled only under the macro.
- History, fill and match logic stay in the top level.

## Test plan
- Defaults; after reset, stream 1,0,1 with `in_valid`=1 -> `out`=1 in the cycle after the third bit; `hit_count`=1. Reset values checked: `out`=0, `hit_count`=0.
- Defaults, `overlap`=1, stream 1,0,1,0,1 -> `out` high after bits 3 and 5, `hit_count`=2. Same stream with `overlap`=0 -> one match only, `hit_count`=1.
- `PAT_W`=4, load 4'b1100. Stream 1,1,0 with `in_valid` low for 3 cycles, then 0 -> match on the 4th accepted bit; `out` holds through the idle cycles.
- Assert `pat_load` and `in_valid` together mid-pattern -> bit dropped, `out`=0, history cleared; the next full pattern matches.
- Drop `reset_n` between clock edges after bits 1,0 -> outputs clear immediately. Then 1 alone -> no match; a full 1,0,1 -> match.
- `CNT_W`=2 with the macro defined, 5 matches -> `hit_count` stops at 3. With the macro undefined -> `hit_count` stays 0 throughout.
